g10_baser_pma_bridge: RTL and testbench



---
 rtl/xgmii_pkg.sv | 51 +++++
 rtl/xgmii_rx_pair.sv | 53 +++++
 rtl/g10_baser_pma_bridge.sv | 98 +++++++++
 tb/tb_g10_baser_pma_bridge.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_pkg.sv
// Shared XGMII constants, TX frame-state type and lane helpers used by the
// 10GBASE-R PCS <-> PMA width bridge.
package xgmii_pkg;

   localparam int unsigned XGMII_WIDTH_BASER = 64;
   localparam int unsigned XGMII_WIDTH_PMA   = 32;
   localparam int unsigned XGMII_LANES_BASER = XGMII_WIDTH_BASER / 8;
   localparam int unsigned XGMII_LANES_PMA   = XGMII_WIDTH_PMA / 8;

   localparam logic [7:0] XGMII_IDLE  = 8'h07;
   localparam logic [7:0] XGMII_START = 8'hFB;
   localparam logic [7:0] XGMII_TERM  = 8'hFD;
   localparam logic [7:0] XGMII_ERROR = 8'hFE;

   typedef enum logic {
      TX_IDLE  = 1'b0,
      TX_FRAME = 1'b1
   } tx_state_e;

   function automatic logic [XGMII_WIDTH_BASER-1:0] fill_baser(input logic [7:0] code);
      return {XGMII_LANES_BASER{code}};
   endfunction

   function automatic logic [XGMII_WIDTH_PMA-1:0] fill_pma(input logic [7:0] code);
      return {XGMII_LANES_PMA{code}};
   endfunction

   // Walk lanes low to high so a Start and a Terminate in one word resolve
   // in the order they appear on the wire.
   function automatic tx_state_e tx_frame_next(
      input tx_state_e                      cur,
      input logic [XGMII_WIDTH_BASER-1:0]   d,
      input logic [XGMII_LANES_BASER-1:0]   c
   );
      tx_state_e  s;
      logic [7:0] b;
      s = cur;
      for (int unsigned lane = 0; lane < XGMII_LANES_BASER; lane++) begin
         b = d[lane*8 +: 8];
         if (c[lane]) begin
            if ((b == XGMII_START) && ((lane == 32'd0) || (lane == 32'd4))) begin
               s = TX_FRAME;
            end else if (b == XGMII_TERM) begin
               s = TX_IDLE;
            end
         end
      end
      return s;
   endfunction

endpackage

// File: rtl/xgmii_rx_pair.sv
// Pairs consecutive valid 32-bit PMA words into one 64-bit XGMII word; the
// first word of a pair becomes lanes 0-3, the second lanes 4-7.
module xgmii_rx_pair
   import xgmii_pkg::*;
(
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [XGMII_WIDTH_PMA-1:0]    i_d,
   input  logic [XGMII_LANES_PMA-1:0]    i_c,
   input  logic                          i_v,
   output logic [XGMII_WIDTH_BASER-1:0]  o_d,
   output logic [XGMII_LANES_BASER-1:0]  o_c,
   output logic                          o_v
);

   logic                          r_have_lo;
   logic [XGMII_WIDTH_PMA-1:0]    r_lo_d;
   logic [XGMII_LANES_PMA-1:0]    r_lo_c;
   logic [XGMII_WIDTH_BASER-1:0]  r_d;
   logic [XGMII_LANES_BASER-1:0]  r_c;
   logic                          r_v;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_have_lo <= 1'b0;
         r_lo_d    <= fill_pma(XGMII_IDLE);
         r_lo_c    <= '1;
         r_d       <= fill_baser(XGMII_IDLE);
         r_c       <= '1;
         r_v       <= 1'b0;
      end else begin
         r_v <= 1'b0;
         // Invalid cycles leave the held low half untouched.
         if (i_v) begin
            if (r_have_lo) begin
               r_d       <= {i_d, r_lo_d};
               r_c       <= {i_c, r_lo_c};
               r_v       <= 1'b1;
               r_have_lo <= 1'b0;
            end else begin
               r_lo_d    <= i_d;
               r_lo_c    <= i_c;
               r_have_lo <= 1'b1;
            end
         end
      end
   end

   assign o_d = r_d;
   assign o_c = r_c;
   assign o_v = r_v;

endmodule

// File: rtl/g10_baser_pma_bridge.sv
// 64-bit <-> 32-bit XGMII bridge between the 10GBASE-R PCS and the PMA
// adaptation layer; TX splits words and replaces in-frame underruns with Error.
module g10_baser_pma_bridge
   import xgmii_pkg::*;
(
   input  logic                          i_clk_156,
   input  logic                          i_rst_156,

   input  logic [XGMII_WIDTH_BASER-1:0]  i_baserTx_d,
   input  logic [XGMII_LANES_BASER-1:0]  i_baserTx_c,
   input  logic                          i_baserTx_v,
   output logic                          o_baserTx_rdy,

   output logic [XGMII_WIDTH_PMA-1:0]    o_pmaTx_d,
   output logic [XGMII_LANES_PMA-1:0]    o_pmaTx_c,
   output logic                          o_pmaTx_v,

   input  logic [XGMII_WIDTH_PMA-1:0]    i_pmaRx_d,
   input  logic [XGMII_LANES_PMA-1:0]    i_pmaRx_c,
   input  logic                          i_pmaRx_v,
   output logic                          o_pmaRx_rdy,

   output logic [XGMII_WIDTH_BASER-1:0]  o_baserRx_d,
   output logic [XGMII_LANES_BASER-1:0]  o_baserRx_c,
   output logic                          o_baserRx_v,

   output logic                          o_tx_underrun
);

   tx_state_e                     r_state;
   logic                          r_ph;
   logic [XGMII_WIDTH_BASER-1:0]  r_word_d;
   logic [XGMII_LANES_BASER-1:0]  r_word_c;
   logic [XGMII_WIDTH_PMA-1:0]    r_pma_d;
   logic [XGMII_LANES_PMA-1:0]    r_pma_c;
   logic                          r_pma_v;
   logic                          r_underrun;

   // r_word holds the word taken at ph=0; its low half goes out on the ph=1
   // edge and its high half on the following ph=0 edge, while the next word
   // is captured in the same cycle.
   always_ff @(posedge i_clk_156 or posedge i_rst_156) begin
      if (i_rst_156) begin
         r_state    <= TX_IDLE;
         r_ph       <= 1'b0;
         r_word_d   <= fill_baser(XGMII_IDLE);
         r_word_c   <= '1;
         r_pma_d    <= fill_pma(XGMII_IDLE);
         r_pma_c    <= '1;
         r_pma_v    <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_pma_v    <= 1'b1;
         r_underrun <= 1'b0;
         r_ph       <= ~r_ph;
         if (r_ph) begin
            r_pma_d <= r_word_d[XGMII_WIDTH_PMA-1:0];
            r_pma_c <= r_word_c[XGMII_LANES_PMA-1:0];
         end else begin
            r_pma_d <= r_word_d[XGMII_WIDTH_BASER-1:XGMII_WIDTH_PMA];
            r_pma_c <= r_word_c[XGMII_LANES_BASER-1:XGMII_LANES_PMA];
            if (i_baserTx_v) begin
               r_word_d <= i_baserTx_d;
               r_word_c <= i_baserTx_c;
               r_state  <= tx_frame_next(r_state, i_baserTx_d, i_baserTx_c);
            end else if (r_state == TX_FRAME) begin
               r_word_d   <= fill_baser(XGMII_ERROR);
               r_word_c   <= '1;
               r_state    <= TX_IDLE;
               r_underrun <= 1'b1;
            end else begin
               r_word_d <= fill_baser(XGMII_IDLE);
               r_word_c <= '1;
            end
         end
      end
   end

   // Ready is held low for as long as reset is asserted.
   assign o_baserTx_rdy = ~r_ph & ~i_rst_156;
   assign o_pmaTx_d     = r_pma_d;
   assign o_pmaTx_c     = r_pma_c;
   assign o_pmaTx_v     = r_pma_v;
   assign o_tx_underrun = r_underrun;
   assign o_pmaRx_rdy   = 1'b1;

   xgmii_rx_pair u_rx_pair (
      .i_clk (i_clk_156),
      .i_rst (i_rst_156),
      .i_d   (i_pmaRx_d),
      .i_c   (i_pmaRx_c),
      .i_v   (i_pmaRx_v),
      .o_d   (o_baserRx_d),
      .o_c   (o_baserRx_c),
      .o_v   (o_baserRx_v)
   );

endmodule

// File: tb/tb_g10_baser_pma_bridge.sv
// Scoreboard bench for g10_baser_pma_bridge: expected PMA TX halves and
// baser RX words are queued as stimulus is applied and compared on output.
module tb_g10_baser_pma_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] tx_d = '0;
   logic [7:0]  tx_c = '0;
   logic        tx_v = 1'b0;
   logic        btx_rdy;
   logic [31:0] ptx_d;
   logic [3:0]  ptx_c;
   logic        ptx_v;
   logic [31:0] prx_d = '0;
   logic [3:0]  prx_c = '0;
   logic        prx_v = 1'b0;
   logic        prx_rdy;
   logic [63:0] brx_d;
   logic [7:0]  brx_c;
   logic        brx_v;
   logic        und;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned n_und = 0;
   int unsigned und_base;
   logic [35:0] txq[$];
   logic [71:0] rxq[$];
   logic [63:0] last_rx_d = '0;
   logic [7:0]  last_rx_c = '0;
   logic [7:0]  lane4;

   always #5 clk = ~clk;

   g10_baser_pma_bridge dut (
      .i_clk_156     (clk),
      .i_rst_156     (rst),
      .i_baserTx_d   (tx_d),
      .i_baserTx_c   (tx_c),
      .i_baserTx_v   (tx_v),
      .o_baserTx_rdy (btx_rdy),
      .o_pmaTx_d     (ptx_d),
      .o_pmaTx_c     (ptx_c),
      .o_pmaTx_v     (ptx_v),
      .i_pmaRx_d     (prx_d),
      .i_pmaRx_c     (prx_c),
      .i_pmaRx_v     (prx_v),
      .o_pmaRx_rdy   (prx_rdy),
      .o_baserRx_d   (brx_d),
      .o_baserRx_c   (brx_c),
      .o_baserRx_v   (brx_v),
      .o_tx_underrun (und)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Frame tracker: Start (lanes 0/4) enters a frame, Terminate leaves it, in lane order.
   function automatic bit model_frame(input bit in_frame, input logic [63:0] d, input logic [7:0] c);
      bit         f;
      logic [7:0] b;
      f = in_frame;
      for (int i = 0; i < 8; i++) begin
         b = d[i*8 +: 8];
         if (c[i] && b == 8'hFB && (i == 0 || i == 4)) f = 1'b1;
         else if (c[i] && b == 8'hFD) f = 1'b0;
      end
      return f;
   endfunction

   initial begin : monitor
      logic [35:0] e;
      logic [71:0] r;
      logic [31:0] pat;
      logic [31:0] lo_d;
      logic [3:0]  lo_c;
      bit ph_m, fr_m, has_lo, exp_und, exp_rxv;
      ph_m = 1'b0; fr_m = 1'b0; has_lo = 1'b0; lo_d = '0; lo_c = '0;
      forever begin
         @(posedge clk);
         if (rst) begin
            ph_m = 1'b0;
            fr_m = 1'b0;
            has_lo = 1'b0;
            txq.delete();
            txq.push_back({4'hF, 32'h07070707});
            rxq.delete();
         end else begin
            exp_und = 1'b0;
            if (!ph_m) begin
               if (tx_v) begin
                  txq.push_back({tx_c[3:0], tx_d[31:0]});
                  txq.push_back({tx_c[7:4], tx_d[63:32]});
                  fr_m = model_frame(fr_m, tx_d, tx_c);
               end else begin
                  pat = fr_m ? 32'hFEFEFEFE : 32'h07070707;
                  txq.push_back({4'hF, pat});
                  txq.push_back({4'hF, pat});
                  exp_und = fr_m;
                  fr_m = 1'b0;
               end
            end
            ph_m = ~ph_m;
            exp_rxv = prx_v && has_lo;
            if (prx_v) begin
               if (has_lo) begin
                  rxq.push_back({prx_c, lo_c, prx_d, lo_d});
                  has_lo = 1'b0;
               end else begin
                  lo_d = prx_d;
                  lo_c = prx_c;
                  has_lo = 1'b1;
               end
            end
            #1;
            check_val("txq_nonempty", 64'(txq.size() != 0), 64'd1);
            if (txq.size() != 0) begin
               e = txq.pop_front();
               check_val("pmaTx_d", 64'(ptx_d), 64'(e[31:0]));
               check_val("pmaTx_c", 64'(ptx_c), 64'(e[35:32]));
            end
            check_val("pmaTx_v", 64'(ptx_v), 64'd1);
            check_val("baserTx_rdy", 64'(btx_rdy), 64'(!ph_m));
            check_val("tx_underrun", 64'(und), 64'(exp_und));
            check_val("baserRx_v", 64'(brx_v), 64'(exp_rxv));
            if (und) n_und++;
            if (brx_v) begin
               last_rx_d = brx_d;
               last_rx_c = brx_c;
               check_val("rxq_nonempty", 64'(rxq.size() != 0), 64'd1);
               if (rxq.size() != 0) begin
                  r = rxq.pop_front();
                  check_val("baserRx_d", brx_d, r[63:0]);
                  check_val("baserRx_c", 64'(brx_c), 64'(r[71:64]));
               end
            end
         end
      end
   end

   task automatic send_tx(input logic [63:0] d, input logic [7:0] c);
      int unsigned k;
      k = 0;
      while (!btx_rdy && k < 4) begin
         @(negedge clk);
         k++;
      end
      if (!btx_rdy) check_val("rdy_timeout", 64'(btx_rdy), 64'd1);
      tx_d = d;
      tx_c = c;
      tx_v = 1'b1;
      @(negedge clk);
   endtask

   task automatic tx_stop();
      tx_v = 1'b0;
   endtask

   task automatic send_rx(input logic [31:0] d, input logic [3:0] c);
      prx_d = d;
      prx_c = c;
      prx_v = 1'b1;
      @(negedge clk);
      prx_v = 1'b0;
   endtask

   task automatic gap(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      gap(3);
      check_val("rst_pmaTx_d", 64'(ptx_d), 64'h07070707);
      check_val("rst_pmaTx_c", 64'(ptx_c), 64'hF);
      check_val("rst_pmaTx_v", 64'(ptx_v), 64'd0);
      check_val("rst_baserRx_d", brx_d, 64'h0707070707070707);
      check_val("rst_baserRx_c", 64'(brx_c), 64'hFF);
      check_val("rst_baserRx_v", 64'(brx_v), 64'd0);
      check_val("rst_rdy", 64'(btx_rdy), 64'd0);
      check_val("rst_underrun", 64'(und), 64'd0);
      check_val("rst_pmaRx_rdy", 64'(prx_rdy), 64'd1);
      rst = 1'b0;
      gap(8);

      send_tx(64'h1122334455667788, 8'h00);
      tx_stop();
      gap(6);

      und_base = n_und;
      send_tx(64'hD5555555555555FB, 8'h01);
      send_tx(64'h0102030405060708, 8'h00);
      tx_stop();
      gap(6);
      check_val("underrun_pulse_once", 64'(n_und - und_base), 64'd1);

      send_tx(64'hD5555555555555FB, 8'h01);
      send_tx(64'hA1A2A3A4A5A6A7A8, 8'h00);
      send_tx(64'h07070707FD112233, 8'hF8);
      tx_stop();
      gap(6);
      check_val("terminated_no_underrun", 64'(n_und - und_base), 64'd1);

      send_tx(64'hD5555555555555FB, 8'h01);
      send_tx(64'h555555FB070707FD, 8'h1F);
      tx_stop();
      gap(6);
      check_val("term_then_start_frame", 64'(n_und - und_base), 64'd2);

      send_tx(64'h07FD5555555555FB, 8'hC1);
      tx_stop();
      gap(6);
      check_val("start_then_term_idle", 64'(n_und - und_base), 64'd2);

      send_rx(32'hAAAA0001, 4'h0);
      gap(3);
      send_rx(32'hBBBB0002, 4'h0);
      gap(2);
      check_val("rx_gap_word", last_rx_d, 64'hBBBB0002AAAA0001);

      send_rx(32'h07070707, 4'hF);
      send_rx(32'h555555FB, 4'h1);
      gap(2);
      lane4 = last_rx_d[39:32];
      check_val("rx_lane4_start", 64'(lane4), 64'hFB);
      check_val("rx_lane4_ctrl", 64'(last_rx_c), 64'h1F);

      send_rx(32'h10000001, 4'h0);
      send_rx(32'h20000002, 4'h0);
      send_rx(32'h30000003, 4'h0);
      send_rx(32'h40000004, 4'h0);
      gap(2);
      check_val("rx_back_to_back", last_rx_d, 64'h4000000430000003);

      send_rx(32'hDEAD0001, 4'h0);
      gap(1);
      rst = 1'b1;
      gap(2);
      rst = 1'b0;
      gap(1);
      send_rx(32'h11110001, 4'h0);
      send_rx(32'h22220002, 4'h0);
      gap(2);
      check_val("rx_after_reset", last_rx_d, 64'h2222000211110001);

      gap(4);
      check_val("rxq_drained", 64'(rxq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
